// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-synchronous test patterns.
// Timing outputs and colours are decoded from the post-update counters, so they stay mutually consistent.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int DIV      = 4,
    parameter int COLOR_W  = 4,
    parameter int CHK_LOG2 = 3,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic                 pix_ce,
    output logic [HW-1:0]        h_pos,
    output logic [VW-1:0]        v_pos,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [31:0] BAR_END = 32'(8 * BAR_W);
    localparam logic [31:0] BAR_DIV = 32'((BAR_W > 0) ? BAR_W : 1);
    localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic [3*COLOR_W-1:0] RGB_ZERO = {(3*COLOR_W){1'b0}};
    localparam logic [3*COLOR_W-1:0] RGB_FULL = {(3*COLOR_W){1'b1}};

    // Colour for one active pixel; the caller blanks it outside the active region.
    function automatic logic [3*COLOR_W-1:0] pixel_rgb(
        input logic [1:0]           m,
        input logic [HW-1:0]        h,
        input logic [VW-1:0]        v,
        input logic [3*COLOR_W-1:0] solid
    );
        logic [2:0]           bar_s;
        logic [3*COLOR_W-1:0] rgb_s;
        bar_s = 3'b000;
        rgb_s = RGB_ZERO;
        case (m)
            2'd0: rgb_s = RGB_ZERO;
            2'd1: begin
                if (32'(h) < BAR_END) begin
                    case (3'(32'(h) / BAR_DIV))
                        3'd0:    bar_s = 3'b111;
                        3'd1:    bar_s = 3'b110;
                        3'd2:    bar_s = 3'b011;
                        3'd3:    bar_s = 3'b010;
                        3'd4:    bar_s = 3'b101;
                        3'd5:    bar_s = 3'b100;
                        3'd6:    bar_s = 3'b001;
                        default: bar_s = 3'b000;
                    endcase
                end else begin
                    bar_s = 3'b000;
                end
                rgb_s = {{COLOR_W{bar_s[2]}}, {COLOR_W{bar_s[1]}}, {COLOR_W{bar_s[0]}}};
            end
            2'd2: rgb_s = ((((32'(h) >> CHK_LOG2) ^ (32'(v) >> CHK_LOG2)) & 32'd1) != 32'd0)
                          ? RGB_FULL : RGB_ZERO;
            2'd3: rgb_s = solid;
            default: rgb_s = RGB_ZERO;
        endcase
        return rgb_s;
    endfunction

    logic [DW-1:0]        div_q, div_d;
    logic [HW-1:0]        h_q, h_d;
    logic [VW-1:0]        v_q, v_d;
    logic                 de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d, solid_q, solid_d;
    logic [1:0]           mode_q, mode_d;
    logic                 ce_s, h_wrap_s, frame_wrap_s;

    // Next-state: divider, raster counters, frame-boundary pattern latch and output decode.
    always_comb begin
        ce_s         = rst && (div_q == DIV_LAST);
        h_wrap_s     = (h_q == H_LAST);
        frame_wrap_s = ce_s && h_wrap_s && (v_q == V_LAST);
        div_d        = (div_q == DIV_LAST) ? {DW{1'b0}} : div_q + DW'(1'b1);
        h_d          = h_q;
        v_d          = v_q;
        if (ce_s) begin
            h_d = h_wrap_s ? {HW{1'b0}} : h_q + HW'(1'b1);
            if (h_wrap_s) begin
                v_d = (v_q == V_LAST) ? {VW{1'b0}} : v_q + VW'(1'b1);
            end else begin
                v_d = v_q;
            end
        end else begin
            h_d = h_q;
        end
        // The new pattern selection applies from pixel (0,0) of the frame it is latched for.
        mode_d  = frame_wrap_s ? mode : mode_q;
        solid_d = frame_wrap_s ? solid_rgb : solid_q;
        fs_d    = ce_s ? frame_wrap_s : fs_q;
        de_d    = (h_d < H_ACT) && (v_d < V_ACT);
        hs_d    = ((h_d >= HS_BEG) && (h_d <= HS_END)) ? SYNC_ON : ~SYNC_ON;
        vs_d    = ((v_d >= VS_BEG) && (v_d <= VS_END)) ? SYNC_ON : ~SYNC_ON;
        rgb_d   = de_d ? pixel_rgb(mode_d, h_d, v_d, solid_d) : RGB_ZERO;
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= {DW{1'b0}};
            h_q     <= {HW{1'b0}};
            v_q     <= {VW{1'b0}};
            de_q    <= 1'b1;
            hs_q    <= ~SYNC_ON;
            vs_q    <= ~SYNC_ON;
            fs_q    <= 1'b0;
            rgb_q   <= RGB_ZERO;
            mode_q  <= 2'd0;
            solid_q <= RGB_ZERO;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            rgb_q   <= rgb_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
        end
    end

    assign pix_ce      = ce_s;
    assign h_pos       = h_q;
    assign v_pos       = v_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;
    assign red         = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign green       = rgb_q[2*COLOR_W-1:COLOR_W];
    assign blue        = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small configurations checked every clock against a
// pixel-count reference model (position derived from elapsed clocks by plain arithmetic).
module tb_vga_timing_gen;

    localparam int A_HA = 16, A_HF = 2, A_HS = 2, A_HB = 2;
    localparam int A_VA = 4,  A_VF = 1, A_VS = 1, A_VB = 1;
    localparam int A_POL = 0, A_DIV = 2, A_CHK = 1;
    localparam int A_FT = (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB);
    localparam int B_HA = 8,  B_HF = 2, B_HS = 2, B_HB = 2;
    localparam int B_VA = 4,  B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_POL = 1, B_DIV = 1, B_CHK = 1;
    localparam int B_FT = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

    typedef struct {
        logic       ce;
        int         h;
        int         v;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid = 12'h000;

    logic       a_ce, a_de, a_hs, a_vs, a_fs;
    logic [4:0] a_h;
    logic [2:0] a_v;
    logic [3:0] a_r, a_g, a_b;
    logic       b_ce, b_de, b_hs, b_vs, b_fs;
    logic [3:0] b_h;
    logic [2:0] b_v;
    logic [3:0] b_r, b_g, b_b;

    int          checks = 0;
    int          fails = 0;
    int          k = 0;
    logic [1:0]  lm_a = 2'd0, lm_b = 2'd0;
    logic [11:0] ls_a = 12'h000, ls_b = 12'h000;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .SYNC_POL(A_POL), .DIV(A_DIV), .COLOR_W(4), .CHK_LOG2(A_CHK)
    ) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid),
        .pix_ce(a_ce), .h_pos(a_h), .v_pos(a_v), .de(a_de),
        .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs),
        .red(a_r), .green(a_g), .blue(a_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .SYNC_POL(B_POL), .DIV(B_DIV), .COLOR_W(4), .CHK_LOG2(B_CHK)
    ) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid),
        .pix_ce(b_ce), .h_pos(b_h), .v_pos(b_v), .de(b_de),
        .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs),
        .red(b_r), .green(b_g), .blue(b_b)
    );

    always #5 clk = ~clk;

    // Expected outputs after kk clock edges since reset release.
    function automatic void model(input int ha, hf, hs, hb, va, vf, vs, vb, pol, dv, chk,
                                  input int kk, input logic rr, input logic [1:0] lm,
                                  input logic [11:0] ls, output exp_t e);
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int p = kk / dv;
        int bars[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
        int bw = ha / 8;
        int bits;
        logic [11:0] rgb = 12'h000;
        e.ce = rr && ((kk % dv) == dv - 1);
        e.h  = p % ht;
        e.v  = (p / ht) % vt;
        e.de = (e.h < ha) && (e.v < va);
        e.hs = (e.h >= ha + hf && e.h < ha + hf + hs) ? (pol != 0) : (pol == 0);
        e.vs = (e.v >= va + vf && e.v < va + vf + vs) ? (pol != 0) : (pol == 0);
        e.fs = (p > 0) && (p % (ht * vt) == 0);
        if (e.de) begin
            case (lm)
                2'd1: begin
                    bits = (e.h / bw < 8) ? bars[e.h / bw] : 0;
                    rgb = {((bits & 4) != 0) ? 4'hF : 4'h0, ((bits & 2) != 0) ? 4'hF : 4'h0,
                           ((bits & 1) != 0) ? 4'hF : 4'h0};
                end
                2'd2: rgb = ((((e.h >> chk) ^ (e.v >> chk)) & 1) != 0) ? 12'hFFF : 12'h000;
                2'd3: rgb = ls;
                default: rgb = 12'h000;
            endcase
        end
        e.r = rgb[11:8];
        e.g = rgb[7:4];
        e.b = rgb[3:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t ea, eb;
        model(A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_POL, A_DIV, A_CHK,
              k, rst, lm_a, ls_a, ea);
        model(B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_POL, B_DIV, B_CHK,
              k, rst, lm_b, ls_b, eb);
        chk("a_pix_ce", 32'(a_ce), 32'(ea.ce));
        chk("a_h_pos", 32'(a_h), 32'(ea.h));
        chk("a_v_pos", 32'(a_v), 32'(ea.v));
        chk("a_de", 32'(a_de), 32'(ea.de));
        chk("a_hsync", 32'(a_hs), 32'(ea.hs));
        chk("a_vsync", 32'(a_vs), 32'(ea.vs));
        chk("a_frame_start", 32'(a_fs), 32'(ea.fs));
        chk("a_rgb", 32'({a_r, a_g, a_b}), 32'({ea.r, ea.g, ea.b}));
        chk("b_pix_ce", 32'(b_ce), 32'(eb.ce));
        chk("b_h_pos", 32'(b_h), 32'(eb.h));
        chk("b_v_pos", 32'(b_v), 32'(eb.v));
        chk("b_de", 32'(b_de), 32'(eb.de));
        chk("b_hsync", 32'(b_hs), 32'(eb.hs));
        chk("b_vsync", 32'(b_vs), 32'(eb.vs));
        chk("b_frame_start", 32'(b_fs), 32'(eb.fs));
        chk("b_rgb", 32'({b_r, b_g, b_b}), 32'({eb.r, eb.g, eb.b}));
    endtask

    // One clock: the inputs present at the edge are what a frame boundary latches.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) begin
            k++;
            if ((k % A_DIV == 0) && (k / A_DIV > 0) && ((k / A_DIV) % A_FT == 0)) begin
                lm_a = mode;
                ls_a = solid;
            end
            if ((k % B_DIV == 0) && (k / B_DIV > 0) && ((k / B_DIV) % B_FT == 0)) begin
                lm_b = mode;
                ls_b = solid;
            end
        end
        check_all();
    endtask

    initial begin
        exp_t pos;
        int guard;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check_all();
        mode = 2'd0;
        repeat (150) step();
        mode = 2'd3;
        solid = 12'h5A3;
        repeat (700) step();
        mode = 2'd1;
        repeat (700) step();
        mode = 2'd2;
        repeat (700) step();
        repeat (1500) begin
            mode = 2'($urandom_range(0, 3));
            solid = 12'($urandom);
            step();
        end
        mode = 2'd3;
        solid = 12'h5A3;
        guard = 0;
        model(A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_POL, A_DIV, A_CHK,
              k, rst, lm_a, ls_a, pos);
        while (!(pos.h == 5 && pos.v == 2) && guard < 1000) begin
            step();
            guard++;
            model(A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_POL, A_DIV, A_CHK,
                  k, rst, lm_a, ls_a, pos);
        end
        chk("reach_h5_v2", 32'(guard < 1000), 32'd1);
        rst = 1'b0;
        k = 0;
        lm_a = 2'd0;
        lm_b = 2'd0;
        ls_a = 12'h000;
        ls_b = 12'h000;
        #1;
        check_all();
        repeat (3) step();
        rst = 1'b1;
        #1;
        check_all();
        repeat (800) step();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing and test-pattern generator driving the board VGA pins (hsync, vsync, 4-bit red/green/blue per channel).
- Generalises the current fixed 640x480 path: all porch, sync and active widths, sync polarity, pixel-clock divide and colour depth are parameters.
- Adds a frame-synchronous pattern mode.
- Sits directly under top, fed from the raw board clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted sync level (0 = active-low)
DIV, 4, clk cycles per pixel (>=1)
COLOR_W, 4, bits per colour channel
CHK_LOG2, 3, checkerboard cell size = 2^CHK_LOG2 pixels

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset (0 = reset)
mode  in  2  pattern select: 0 black, 1 colour bars, 2 checkerboard, 3 solid
solid_rgb  in  3*COLOR_W  solid colour {r,g,b} for mode 3
pix_ce  out  1  pixel-rate strobe, one clk wide
h_pos  out  clog2(H_TOTAL)  current column counter
v_pos  out  clog2(V_TOTAL)  current line counter
de  out  1  data enable, high in active region
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
frame_start  out  1  high for pixel (0,0) after a wrap
red  out  COLOR_W  red channel
green  out  COLOR_W  green channel
blue  out  COLOR_W  blue channel

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous. Defaults give 800 x 525.
- Divider div_cnt runs 0..DIV-1. pix_ce=1 in the cycle where div_cnt==DIV-1. DIV=1 gives pix_ce constantly 1 after reset.
- On each clk edge with pix_ce=1:
  - h_pos increments, wrapping H_TOTAL-1 -> 0.
  - On an h wrap, v_pos increments, wrapping V_TOTAL-1 -> 0.
- All outputs except pix_ce are registered, decoded from the post-update counter values, and therefore mutually consistent. Each value holds for DIV clk cycles.
- Decodes:
  - de = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE).
  - hsync = SYNC_POL when h_pos is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~SYNC_POL.
  - vsync is the same decode on v_pos with the V_* parameters.
- frame_start = 1 only when (h,v) becomes (0,0) through a wrap.
- Pattern registers: mode and solid_rgb are latched into internal registers only on the transition into (0,0), including the first one after reset. Mid-frame changes take effect at the next frame.
- Colour when de=0: red/green/blue = 0. When de=1:
  - Mode 0: all zero.
  - Mode 1: 8 bars, each H_ACTIVE/8 px wide. Order left-to-right: white, yellow, cyan, green, magenta, red, blue, black. Channels are full scale (all ones) or 0. Columns past 8*(H_ACTIVE/8) use black.
  - Mode 2: white if ((h_pos>>CHK_LOG2) ^ (v_pos>>CHK_LOG2)) & 1, else black.
  - Mode 3: latched solid_rgb.
- Reset (async, rst=0):
  - div_cnt=0, h_pos=0, v_pos=0, pix_ce=0.
  - de=1, hsync=vsync=~SYNC_POL, frame_start=0.
  - Colours 0; latched mode=0; latched solid=0.
  - The latched-mode=0 reset value forces black until the first wrap.
- Reset mid-frame: everything returns immediately to the reset values. After release, the first pix_ce occurs DIV clk cycles later.
- Simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1) produce (0,0) in the same edge, with frame_start=1.

Test Plan:
- DIV=4, defaults, rst low 5 clk then high -> pix_ce period 4 clk; h_pos=1 after first pix_ce; hsync low for exactly 96*4 clk per line, starting at h_pos=656; line period 3200 clk.
- Small params (H 8/2/2/2, V 4/1/1/1, DIV=1) -> de high 8 of 14 columns on lines 0-3; vsync low only on line 5; frame_start once every 98 clk, at (0,0).
- SYNC_POL=1 with the small params -> hsync/vsync polarity inverted; timing identical.
- mode=1, H_ACTIVE=16 -> pixel pairs read white, yellow, cyan, green, magenta, red, blue, black (e.g. yellow = F/F/0); outside de all zero.
- mode switched 0->3 (solid_rgb=0x5A3) mid-frame -> output stays black until the next frame_start, then shows 5/A/3 on every de pixel.
- rst asserted at h_pos=5, v_pos=2 -> outputs go to reset values in the same cycle with no clk edge; after release, counting restarts from (0,0); the first frame_start occurs only after a full frame.
